// File: rtl/dp_ram_be.sv
// Dual-port byte-enable RAM with a clear engine and a configurable read latency (1 or 2).
// Define DP_RAM_PARITY_EN to store an even-parity bit per byte and expose par_inj / par_err.

module dp_ram_be_lane #(
   parameter int LW  = 8,
   parameter int AW  = 10,
   parameter int RDW = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [LW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [LW-1:0] rd_data
);
   logic [LW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register holds its value between accepted reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         if (RDW == 1 && wr_en && wr_addr == rd_addr) rd_data <= wr_data;
         else                                          rd_data <= mem[rd_addr];
      end
   end
endmodule

module dp_ram_be #(
   parameter int Data_width   = 32,
   parameter int Addr_width   = 10,
   parameter int Read_latency = 1,
   parameter int Rdw_mode     = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clr,
   input  logic                    we,
   input  logic [Data_width/8-1:0] be,
   input  logic [Addr_width-1:0]   w_addr,
   input  logic [Data_width-1:0]   d,
   input  logic                    re,
   input  logic [Addr_width-1:0]   r_addr,
`ifdef DP_RAM_PARITY_EN
   input  logic                    par_inj,
   output logic [Data_width/8-1:0] par_err,
`endif
   output logic [Data_width-1:0]   q,
   output logic                    rd_valid,
   output logic                    busy
);
   localparam int NL     = Data_width / 8;
   localparam int STAGES = (Read_latency == 2) ? 2 : 1;
`ifdef DP_RAM_PARITY_EN
   localparam int LW = 9;
`else
   localparam int LW = 8;
`endif

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state;
   logic [Addr_width-1:0]   cnt;
   logic                    accept;
   logic                    vld_pipe [0:STAGES];
   logic [NL-1:0]           lane_we;
   logic [Addr_width-1:0]   lane_waddr;
   logic [NL-1:0][LW-1:0]   lane_wdata;
   logic [NL-1:0][LW-1:0]   lane_rdata;
   logic [NL-1:0][LW-1:0]   out_r;

   // Clear engine: one zero write per cycle; clr restarts the sweep from address 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CLEAR;
         cnt   <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               if (clr) begin
                  cnt <= '0;
               end else if (cnt == '1) begin
                  cnt   <= '0;
                  state <= READY;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            READY: begin
               if (clr) begin
                  cnt   <= '0;
                  state <= CLEAR;
                  busy  <= 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   assign accept      = re & ~busy;
   assign lane_waddr  = busy ? cnt : w_addr;
   assign vld_pipe[0] = accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= 1'b0;
      end else begin
         for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   for (genvar i = 0; i < NL; i++) begin : g_lane
      assign lane_we[i] = busy | (we & be[i]);
`ifdef DP_RAM_PARITY_EN
      // Even parity, optionally inverted to let software exercise the checker.
      assign lane_wdata[i] = busy ? '0 : {(^d[8*i +: 8]) ^ par_inj, d[8*i +: 8]};
      assign par_err[i]    = ^out_r[i];
`else
      assign lane_wdata[i] = busy ? '0 : d[8*i +: 8];
`endif
      assign q[8*i +: 8] = out_r[i][7:0];

      dp_ram_be_lane #(
         .LW  (LW),
         .AW  (Addr_width),
         .RDW (Rdw_mode)
      ) u_lane (
         .clk     (clk),
         .reset_n (reset_n),
         .wr_en   (lane_we[i]),
         .wr_addr (lane_waddr),
         .wr_data (lane_wdata[i]),
         .rd_en   (accept),
         .rd_addr (r_addr),
         .rd_data (lane_rdata[i])
      );
   end

   if (STAGES == 2) begin : g_lat2
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)         out_r <= '0;
         else if (vld_pipe[1]) out_r <= lane_rdata;
      end
   end else begin : g_lat1
      assign out_r = lane_rdata;
   end

   assign rd_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_dp_ram_be.sv
// Randomized bench for dp_ram_be: two instances (latency 1 / read-old, latency 2 / write-first)
// share stimulus and are compared against a word-level memory model.
module tb_dp_ram_be;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          clr = 0, we = 0, re = 0;
   logic [3:0]    be = '0;
   logic [AW-1:0] w_addr = '0, r_addr = '0;
   logic [DW-1:0] d = '0;
   logic [DW-1:0] q_a, q_b;
   logic          vld_a, vld_b, busy_a, busy_b;
`ifdef DP_RAM_PARITY_EN
   logic          par_inj = 1'b0;
   logic [3:0]    par_err_a, par_err_b;
   logic [3:0]    inj_m [DEPTH];
   logic [3:0]    e1_pe, e2_pe, s2_pe;
`endif

   int tests = 0, fails = 0;

   // Reference model state
   logic [DW-1:0] mem_m [DEPTH];
   bit            m_busy;
   int            m_idx;
   logic [DW-1:0] e1_q, e2_q, s2_d;
   bit            e1_v, e2_v, s2_v;

   always #5 clk = ~clk;

   dp_ram_be #(.Data_width(DW), .Addr_width(AW), .Read_latency(1), .Rdw_mode(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .clr(clr), .we(we), .be(be), .w_addr(w_addr), .d(d),
      .re(re), .r_addr(r_addr),
`ifdef DP_RAM_PARITY_EN
      .par_inj(par_inj), .par_err(par_err_a),
`endif
      .q(q_a), .rd_valid(vld_a), .busy(busy_a));

   dp_ram_be #(.Data_width(DW), .Addr_width(AW), .Read_latency(2), .Rdw_mode(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .clr(clr), .we(we), .be(be), .w_addr(w_addr), .d(d),
      .re(re), .r_addr(r_addr),
`ifdef DP_RAM_PARITY_EN
      .par_inj(par_inj), .par_err(par_err_b),
`endif
      .q(q_b), .rd_valid(vld_b), .busy(busy_b));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: advance the model from the current inputs, then compare both DUTs.
   task automatic tick();
      logic [DW-1:0] old, merged, bmask;
      bit acc, hit;
      acc = re && !m_busy;
      hit = we && !m_busy && (w_addr == r_addr);
      old = mem_m[r_addr];
      bmask = '0;
      for (int i = 0; i < 4; i++) if (be[i]) bmask[8*i +: 8] = 8'hFF;
      merged = (d & bmask) | (old & ~bmask);
`ifdef DP_RAM_PARITY_EN
      begin
         logic [3:0] oldp, newp;
         oldp = inj_m[r_addr];
         newp = (oldp & ~be) | (par_inj ? be : 4'h0);
         e2_pe = s2_pe;
         if (acc) begin
            e1_pe = oldp;
            s2_pe = hit ? newp : oldp;
         end
      end
`endif
      e2_v = s2_v;
      if (s2_v) e2_q = s2_d;
      s2_v = acc;
      if (acc) s2_d = hit ? merged : old;
      e1_v = acc;
      if (acc) e1_q = old;
      if (m_busy) begin
         mem_m[m_idx] = '0;
`ifdef DP_RAM_PARITY_EN
         inj_m[m_idx] = '0;
`endif
         if (clr)                     m_idx = 0;
         else if (m_idx == DEPTH - 1) m_busy = 0;
         else                         m_idx++;
      end else begin
         if (we) begin
            mem_m[w_addr] = (d & bmask) | (mem_m[w_addr] & ~bmask);
`ifdef DP_RAM_PARITY_EN
            inj_m[w_addr] = (inj_m[w_addr] & ~be) | (par_inj ? be : 4'h0);
`endif
         end
         if (clr) begin
            m_busy = 1;
            m_idx = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("busy_a", busy_a, m_busy);
      chk("busy_b", busy_b, m_busy);
      chk("vld_a", vld_a, e1_v);
      chk("vld_b", vld_b, e2_v);
      chk("q_a", q_a, e1_q);
      chk("q_b", q_b, e2_q);
`ifdef DP_RAM_PARITY_EN
      if (e1_v) chk("perr_a", par_err_a, e1_pe);
      if (e2_v) chk("perr_b", par_err_b, e2_pe);
`endif
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      chk("rst_q_a", q_a, 0);
      chk("rst_q_b", q_b, 0);
      chk("rst_vld_a", vld_a, 0);
      chk("rst_vld_b", vld_b, 0);
      chk("rst_busy_a", busy_a, 1);
      chk("rst_busy_b", busy_b, 1);
      m_busy = 1; m_idx = 0;
      e1_q = '0; e2_q = '0; s2_d = '0;
      e1_v = 0; e2_v = 0; s2_v = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic idle();
      clr = 0; we = 0; re = 0; be = '0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v, input logic [3:0] m);
      we = 1; w_addr = a; d = v; be = m;
      tick();
      we = 0;
   endtask

   task automatic busy_len(input string tag, input int start);
      int n;
      n = start;
      while (busy_a && n < 4 * DEPTH) begin
         tick();
         n++;
      end
      chk(tag, n, DEPTH);
   endtask

   task automatic read_all_zero(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         re = 1; r_addr = a[AW-1:0];
         tick();
         chk(tag, {vld_a, q_a}, {1'b1, 32'h0});
      end
      re = 0;
      tick();
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         mem_m[a] = '0;
`ifdef DP_RAM_PARITY_EN
         inj_m[a] = '0;
`endif
      end
      reset_n = 1'b1;
      #1;
      do_reset();

      // Power-on clear sweep, then every word reads back zero.
      busy_len("t1_busy_len", 0);
      read_all_zero("t1_rd0");

      // Partial byte-enable merge.
      wr(3, 32'hAABBCCDD, 4'b1111);
      wr(3, 32'h11223344, 4'b0100);
      re = 1; r_addr = 3;
      tick();
      re = 0;
      chk("t2_q_a", q_a, 32'hAA22CCDD);
      chk("t2_vld_a", vld_a, 1);
      tick();
      chk("t2_pulse_a", vld_a, 0);
      chk("t2_q_b", q_b, 32'hAA22CCDD);
      tick();

      // Same-address read during write.
      wr(5, 32'h12345678, 4'hF);
      we = 1; w_addr = 5; d = 32'hDEADBEEF; be = 4'hF; re = 1; r_addr = 5;
      tick();
      idle();
      chk("t3_old_a", q_a, 32'h12345678);
      tick();
      chk("t3_new_b", q_b, 32'hDEADBEEF);
      tick();

      // Back-to-back reads through the two-stage pipeline.
      for (int a = 1; a <= 3; a++) wr(a[AW-1:0], 32'hC0DE0000 | a, 4'hF);
      for (int k = 0; k < 5; k++) begin
         re = (k < 3); r_addr = AW'(k + 1);
         tick();
         chk("t4_vld_b", vld_b, (k >= 1 && k <= 3));
         if (k >= 1 && k <= 3) chk("t4_q_b", q_b, 32'hC0DE0000 | k);
      end
      idle();

      // Software clear with a read attempted while busy.
      clr = 1;
      tick();
      clr = 0; re = 1; r_addr = 3;
      tick();
      re = 0;
      chk("t5_drop_a", vld_a, 0);
      busy_len("t5_busy_len", 1);
      read_all_zero("t5_rd0");

      // Reset in the middle of a clear restarts the full sweep.
      wr(9, 32'h55AA55AA, 4'hF);
      clr = 1;
      tick();
      clr = 0;
      repeat (7) tick();
      do_reset();
      busy_len("t5_rst_len", 0);
      read_all_zero("t5_rst_rd0");

`ifdef DP_RAM_PARITY_EN
      par_inj = 1;
      wr(7, 32'h000000FF, 4'b0001);
      par_inj = 0;
      re = 1; r_addr = 7;
      tick();
      re = 0;
      chk("t6_perr_inj", par_err_a, 4'b0001);
      wr(7, 32'h000000FF, 4'b0001);
      re = 1; r_addr = 7;
      tick();
      re = 0;
      chk("t6_perr_ok", par_err_a, 4'b0000);
      tick();
`endif

      // Random traffic, including occasional clears.
      for (int c = 0; c < 500; c++) begin
         clr    = ($urandom_range(0, 63) == 0);
         we     = $urandom_range(0, 1);
         re     = $urandom_range(0, 1);
         be     = 4'($urandom);
         w_addr = AW'($urandom);
         r_addr = ($urandom_range(0, 3) == 0) ? w_addr : AW'($urandom);
         d      = $urandom;
`ifdef DP_RAM_PARITY_EN
         par_inj = ($urandom_range(0, 7) == 0);
`endif
         tick();
      end
      idle();
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
